// File: rtl/dm_access_pkg.sv
// Shared types for the data-memory access controller: FSM state encoding and
// host status mode codes.
package dm_access_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_LOAD = 2'b10;
   localparam logic [1:0] ST_DUMP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_LOAD,
      S_DUMP_REQ,
      S_DUMP_WAIT,
      S_DUMP_HOLD,
      S_DONE
   } state_e;

   function automatic logic state_busy(input state_e s);
      return (s == S_LOAD) || (s == S_DUMP_REQ) || (s == S_DUMP_WAIT) || (s == S_DUMP_HOLD);
   endfunction

endpackage

// File: rtl/dm_access_ctrl_xfer_counter.sv
// xfer_counter: burst address register plus length down-counter with load,
// step, zero and last-word flags. Address wraps modulo 2^ADDR_W.
module xfer_counter #(
   parameter int ADDR_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] len_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              zero_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [ADDR_W-1:0] cnt_d, cnt_q;

   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         addr_d = base_i;
         cnt_d  = len_i;
      end else if (step_i) begin
         addr_d = addr_q + ADDR_W'(1);
         cnt_d  = cnt_q - ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr_o = addr_q;
   assign zero_o = (cnt_q == '0);
   assign last_o = (cnt_q == ADDR_W'(1));

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: RUN passthrough of core accesses, host burst
// load/dump with handshakes. Define DM_ACCESS_CTRL_CSUM_EN to add the csum_o port.
module dm_access_ctrl
   import dm_access_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [1:0]        status_i,
   input  logic              core_dm_en_i,
   input  logic              core_im_en_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   input  logic              host_start_i,
   input  logic [ADDR_W-1:0] host_base_i,
   input  logic [ADDR_W-1:0] host_len_i,
   input  logic              host_wvalid_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              host_wready_o,
   output logic              host_rvalid_o,
   output logic [DATA_W-1:0] host_rdata_o,
   input  logic              host_rready_i,
   output logic              dm_en_o,
   output logic              im_en_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [DATA_W-1:0] dm_wdata_o,
   input  logic [DATA_W-1:0] dm_rdata_i,
   output logic              busy_o,
   output logic              done_o,
`ifdef DM_ACCESS_CTRL_CSUM_EN
   output logic [DATA_W-1:0] csum_o,
`endif
   output logic              err_o
);

   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_e            state_q;
   logic [2:0]        lat_q;
   logic              dm_en_q, im_en_q, rvalid_q, done_q, err_q;
   logic [ADDR_W-1:0] dm_addr_q;
   logic [DATA_W-1:0] dm_wdata_q, rdata_q;

   logic              abort, wr_beat, rd_beat, cap;
   logic              cnt_load, cnt_step, cnt_zero, cnt_last;
   logic [ADDR_W-1:0] cnt_addr;
   logic [1:0]        mode;

   assign busy_o        = state_busy(state_q);
   assign mode          = (state_q == S_LOAD) ? ST_LOAD : ST_DUMP;
   assign abort         = busy_o && (status_i != mode);
   // wready is withheld in the abort cycle so no beat is accepted and then dropped
   assign host_wready_o = (state_q == S_LOAD) && (status_i == ST_LOAD);
   assign wr_beat       = host_wvalid_i && host_wready_o;
   assign rd_beat       = (state_q == S_DUMP_HOLD) && rvalid_q && host_rready_i && !abort;
   assign cap           = (state_q == S_DUMP_WAIT) && (lat_q == LAT_LAST) && !abort;
   assign cnt_load      = (state_q == S_IDLE) && host_start_i && status_i[1];
   assign cnt_step      = (wr_beat || rd_beat) && !cnt_zero;

   xfer_counter #(.ADDR_W(ADDR_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (cnt_load),
      .base_i (host_base_i),
      .len_i  (host_len_i),
      .step_i (cnt_step),
      .addr_o (cnt_addr),
      .zero_o (cnt_zero),
      .last_o (cnt_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         lat_q      <= '0;
         dm_en_q    <= 1'b0;
         im_en_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (abort) begin
            state_q  <= S_IDLE;
            err_q    <= 1'b1;
            dm_en_q  <= 1'b0;
            rvalid_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  dm_en_q <= 1'b0;
                  im_en_q <= 1'b0;
                  if (host_start_i && status_i == ST_LOAD) begin
                     state_q <= (host_len_i == '0) ? S_DONE : S_LOAD;
                  end else if (host_start_i && status_i == ST_DUMP) begin
                     state_q   <= (host_len_i == '0) ? S_DONE : S_DUMP_REQ;
                     dm_addr_q <= host_base_i;
                  end else if (status_i == ST_RUN) begin
                     state_q <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (status_i == ST_RUN) begin
                     dm_en_q    <= core_dm_en_i;
                     im_en_q    <= core_im_en_i;
                     dm_addr_q  <= core_addr_i;
                     dm_wdata_q <= core_wdata_i;
                  end else begin
                     dm_en_q <= 1'b0;
                     im_en_q <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               S_LOAD: begin
                  dm_en_q <= wr_beat;
                  if (wr_beat) begin
                     dm_addr_q  <= cnt_addr;
                     dm_wdata_q <= host_wdata_i;
                     if (cnt_last) state_q <= S_DONE;
                  end
               end
               S_DUMP_REQ: begin
                  dm_en_q <= 1'b0;
                  lat_q   <= '0;
                  state_q <= S_DUMP_WAIT;
               end
               S_DUMP_WAIT: begin
                  if (cap) begin
                     rdata_q  <= dm_rdata_i;
                     rvalid_q <= 1'b1;
                     state_q  <= S_DUMP_HOLD;
                  end else begin
                     lat_q <= lat_q + 3'd1;
                  end
               end
               S_DUMP_HOLD: begin
                  if (rd_beat) begin
                     rvalid_q <= 1'b0;
                     if (cnt_last) begin
                        state_q <= S_DONE;
                     end else begin
                        state_q   <= S_DUMP_REQ;
                        dm_addr_q <= cnt_addr + ADDR_W'(1);
                     end
                  end
               end
               S_DONE: begin
                  dm_en_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign dm_en_o       = dm_en_q;
   assign im_en_o       = im_en_q;
   assign dm_addr_o     = dm_addr_q;
   assign dm_wdata_o    = dm_wdata_q;
   assign host_rvalid_o = rvalid_q;
   assign host_rdata_o  = rdata_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

`ifdef DM_ACCESS_CTRL_CSUM_EN
   logic [DATA_W-1:0] csum_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         csum_q <= '0;
      end else if (cnt_load) begin
         csum_q <= '0;
      end else if (wr_beat) begin
         csum_q <= csum_q + host_wdata_i;
      end else if (cap) begin
         csum_q <= csum_q + dm_rdata_i;
      end
   end

   assign csum_o = csum_q;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl (RD_LAT=2) with a modelled read pipeline
// whose data is a fixed function of the address.
module tb_dm_access_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 16;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        status;
   logic              core_dm_en, core_im_en;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              host_start;
   logic [ADDR_W-1:0] host_base, host_len;
   logic              host_wvalid;
   logic [DATA_W-1:0] host_wdata;
   logic              host_wready, host_rvalid, host_rready;
   logic [DATA_W-1:0] host_rdata;
   logic              dm_en, im_en;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata, dm_rdata;
   logic              busy, done, err;
`ifdef DM_ACCESS_CTRL_CSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dm_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .status_i      (status),
      .core_dm_en_i  (core_dm_en),
      .core_im_en_i  (core_im_en),
      .core_addr_i   (core_addr),
      .core_wdata_i  (core_wdata),
      .host_start_i  (host_start),
      .host_base_i   (host_base),
      .host_len_i    (host_len),
      .host_wvalid_i (host_wvalid),
      .host_wdata_i  (host_wdata),
      .host_wready_o (host_wready),
      .host_rvalid_o (host_rvalid),
      .host_rdata_o  (host_rdata),
      .host_rready_i (host_rready),
      .dm_en_o       (dm_en),
      .im_en_o       (im_en),
      .dm_addr_o     (dm_addr),
      .dm_wdata_o    (dm_wdata),
      .dm_rdata_i    (dm_rdata),
      .busy_o        (busy),
      .done_o        (done),
`ifdef DM_ACCESS_CTRL_CSUM_EN
      .csum_o        (csum),
`endif
      .err_o         (err)
   );

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   logic [7:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_f(dm_addr);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign dm_rdata = rd_pipe[RD_LAT-1];

   int         wr_cnt = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic [15:0] wa_log [16];
   logic [7:0]  wd_log [16];
   always @(posedge clk) begin
      if (dm_en) begin
         wa_log[wr_cnt % 16] <= dm_addr;
         wd_log[wr_cnt % 16] <= dm_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {25'd0, dm_en, im_en, host_wready, host_rvalid, busy, done, err}, 32'd0);
      chk({tag, "_addr"}, 32'(dm_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(dm_wdata), 32'd0);
      chk({tag, "_rdata"}, 32'(host_rdata), 32'd0);
   endtask

   task automatic wait_rvalid(output int n);
      n = 0;
      while (!host_rvalid && n < 10) begin
         tick();
         n++;
      end
   endtask

   task automatic start_burst(input logic [1:0] st, input logic [15:0] base, input logic [15:0] len);
      status     = st;
      host_base  = base;
      host_len   = len;
      host_start = 1'b1;
      tick();
      host_start = 1'b0;
   endtask

   initial begin
      int lat, w0, d0, e0;
      logic [15:0] a;
      logic [7:0]  held;
      rst_n = 1'b1; status = 2'b00; core_dm_en = 0; core_im_en = 0; core_addr = '0;
      core_wdata = '0; host_start = 0; host_base = '0; host_len = '0; host_wvalid = 0;
      host_wdata = '0; host_rready = 0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // RUN passthrough
      status = 2'b01; core_dm_en = 1; core_addr = 16'h0010; core_wdata = 8'hA5;
      tick(); tick();
      chk("run_dm_en", 32'(dm_en), 32'd1);
      chk("run_addr", 32'(dm_addr), 32'h0010);
      chk("run_wdata", 32'(dm_wdata), 32'hA5);
      chk("run_im_en0", 32'(im_en), 32'd0);
      core_dm_en = 0; core_im_en = 1;
      tick();
      chk("run_im_en1", {30'd0, im_en, dm_en}, 32'b10);
      status = 2'b00;
      tick();
      chk("run_exit_en", {30'd0, im_en, dm_en}, 32'b00);
      core_im_en = 0;
      tick();

      // load with address wrap
      d0 = done_cnt;
      start_burst(2'b10, 16'hFFFE, 16'd4);
      chk("load_wready_busy", {30'd0, host_wready, busy}, 32'b11);
      for (int i = 0; i < 4; i++) begin
         host_wvalid = 1; host_wdata = 8'(i + 1);
         tick();
         a = 16'hFFFE + 16'(i);
         chk("load_en", 32'(dm_en), 32'd1);
         chk("load_addr", 32'(dm_addr), 32'(a));
         chk("load_data", 32'(dm_wdata), 32'(i + 1));
      end
      host_wvalid = 0;
      chk("load_wready_off", 32'(host_wready), 32'd0);
      tick();
      chk("load_done", {30'd0, done, dm_en}, 32'b10);
      tick();
      chk("load_done_cnt", 32'(done_cnt - d0), 32'd1);
`ifdef DM_ACCESS_CTRL_CSUM_EN
      chk("load_csum", 32'(csum), 32'h0A);
`endif

      // dump, RD_LAT=2, stall on word 1
      d0 = done_cnt;
      start_burst(2'b11, 16'h0020, 16'd3);
      chk("dump_req_addr", 32'(dm_addr), 32'h0020);
      chk("dump_busy", {30'd0, busy, dm_en}, 32'b10);
      for (int w = 0; w < 3; w++) begin
         wait_rvalid(lat);
         chk("dump_lat", 32'(lat), 32'd3);
         chk("dump_rdata", 32'(host_rdata), 32'(mem_f(16'h0020 + 16'(w))));
         if (w == 1) begin
            held = host_rdata;
            for (int s = 0; s < 3; s++) begin
               tick();
               chk("dump_stall", {23'd0, host_rvalid, host_rdata}, {23'd1, held});
            end
         end
         host_rready = 1;
         tick();
         host_rready = 0;
         chk("dump_rvalid_drop", 32'(host_rvalid), 32'd0);
      end
      tick(); tick(); tick();
      chk("dump_done_cnt", 32'(done_cnt - d0), 32'd1);

      // zero-length load
      w0 = wr_cnt; d0 = done_cnt;
      start_burst(2'b10, 16'h0100, 16'd0);
      repeat (4) tick();
      chk("len0_done", 32'(done_cnt - d0), 32'd1);
      chk("len0_nowrite", 32'(wr_cnt - w0), 32'd0);

      // abort during load by switching to RUN
      e0 = err_cnt;
      start_burst(2'b10, 16'h0040, 16'd8);
      w0 = wr_cnt;
      for (int i = 0; i < 3; i++) begin
         host_wvalid = 1; host_wdata = 8'(8'h11 * (i + 1));
         tick();
      end
      host_wvalid = 0; status = 2'b01;
      core_dm_en = 1; core_addr = 16'h0077; core_wdata = 8'h5C;
      tick();
      chk("abort_err", {29'd0, err, host_wready, busy}, 32'b100);
      chk("abort_dm_en", 32'(dm_en), 32'd0);
      tick();
      chk("abort_err_off", 32'(err), 32'd0);
      chk("abort_writes", 32'(wr_cnt - w0), 32'd3);
      chk("abort_last_wr", {8'd0, wa_log[(w0 + 2) % 16], wd_log[(w0 + 2) % 16]}, 32'h0042_33);
      tick();
      chk("abort_run", {15'd0, dm_en, dm_addr}, {15'd1, 16'h0077});
      status = 2'b00; core_dm_en = 0;
      tick(); tick();
      chk("abort_err_cnt", 32'(err_cnt - e0), 32'd1);

      // asynchronous reset in the middle of a dump
      d0 = done_cnt; e0 = err_cnt;
      start_burst(2'b11, 16'h0030, 16'd3);
      tick();
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      tick(); tick();
      chk("mid_rst_hold", {25'd0, dm_en, im_en, host_wready, host_rvalid, busy, done, err}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("mid_rst_no_pulse", 32'({done_cnt - d0, err_cnt - e0}), 32'd0);
      d0 = done_cnt;
      start_burst(2'b11, 16'h0050, 16'd1);
      wait_rvalid(lat);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_rdata", 32'(host_rdata), 32'(mem_f(16'h0050)));
      host_rready = 1;
      tick();
      host_rready = 0;
      tick(); tick(); tick();
      chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
      status = 2'b00;
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
